wb_stage_regfile: RTL
=====================

Name: wb_stage_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the writeback stage plus the architectural register file it writes.
- Selects the writeback result: ALU result, load-extended memory data, or PC+4.
- Writes the result into a 32x32 register file with x0 hardwired to zero.
- Serves the two decode-stage read ports with same-cycle write-through bypass, and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, number of architectural registers; index width is log2(NREGS)=5
- CNT_W, 64, width of the retired-instruction counter

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  MEM/WB slot holds a real instruction (0 = bubble)
- reg_write_wb  input  1  instruction writes rd
- result_src_wb  input  2  00 ALU, 01 load data, 10 PC+4, 11 reserved
- funct3_wb  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- alu_result_wb  input  XLEN  ALU result; bits [1:0] give the load byte offset
- read_data_wb  input  XLEN  raw aligned word from data memory
- pc_p_4_wb  input  XLEN  PC+4 of the instruction
- rd_wb  input  5  destination register
- rs1_id  input  5  decode read address A
- rs2_id  input  5  decode read address B
- rd1_id  output  XLEN  read data A
- rd2_id  output  XLEN  read data B
- wb_data  output  XLEN  selected writeback value, for forwarding to EX
- wb_we  output  1  effective write enable this cycle
- instret  output  CNT_W  count of retired instructions

Behaviour:
- Load extraction (combinational), with off = alu_result_wb[1:0]:
  - Byte lane = read_data_wb[8*off +: 8]; LB sign-extends, LBU zero-extends.
  - Half lane = read_data_wb[16*off[1] +: 16]; off[0] is ignored. LH sign-extends, LHU zero-extends.
  - LW and undefined funct3 (011, 110, 111) pass the full word.
- Result select: 00 ALU, 01 extracted load, 10 pc_p_4_wb, 11 wb_data=0.
- wb_we = wb_valid & reg_write_wb & (rd_wb!=0) & (result_src_wb!=11).
- Write: on posedge clk, if wb_we, regs[rd_wb] <= wb_data.
  - x0 is never written and always reads 0.
- Read (combinational):
  - rs==0 returns 0.
  - Else if wb_we and rs==rd_wb, returns wb_data (write-through bypass, same cycle).
  - Else returns regs[rs].
  - Both ports resolve independently; rs1==rs2 is legal.
- instret: increments by 1 on posedge when wb_valid=1.
  - Counts regardless of reg_write_wb or rd (stores, branches, rd=x0 retire).
  - Wraps from all-ones to 0 with no flag.
- Latency: written value is visible via bypass in the write cycle, and from the array from the next cycle on.
- Reset (async, rst_n=0):
  - All regs and instret clear to 0 immediately, independent of clk.
  - Outputs then reflect the cleared state: rd1_id/rd2_id = 0 unless bypassing, wb_data/wb_we remain combinational.
  - No write or count occurs on any edge while rst_n=0.
  - A write pending when reset asserts is discarded.
- Reset release: the first posedge with rst_n=1 performs normal writes and counts.
- Bubbles (wb_valid=0): no write, no count; inputs are don't-care.

Test Plan:
- Reset then read: rst_n=0 mid-cycle after x5=0xDEADBEEF is written -> rd1_id for rs1=5 reads 0 immediately, instret=0.
- ALU write + bypass: wb_valid=1, reg_write=1, src=00, alu=0x1234, rd=7, rs1=7 -> rd1_id=0x1234 in the same cycle; after the edge, with wb_valid=0, rd1_id still reads 0x1234.
- Load extension: read_data=0x80FF7F01, funct3=LB, off=3 -> 0xFFFFFF80; LBU off=1 -> 0x7F; LH off=2 -> 0xFFFF80FF; LHU off=3 -> 0x80FF; LW -> 0x80FF7F01.
- x0 and reserved src: rd=0, alu=0x55 -> wb_we=0, rs1=0 reads 0; src=11, rd=3 -> wb_we=0, x3 unchanged.
- JAL link: src=10, pc_p_4=0x00000104, rd=1 -> x1=0x104 after the edge; wb_data=0x104 during the cycle.
- instret: 10 cycles with wb_valid pattern 1101101011 (7 ones, includes stores) -> instret=7; preload near wrap (count up from reset with forced value in sim) -> wraps to 0.

Source files
------------

// File: rtl/wb_stage_regfile.sv
// Writeback stage: selects and load-extends the result, writes the 32-entry register file,
// serves two bypassed decode read ports and counts retired instructions.
module wb_stage_regfile #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned CNT_W = 64,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic             reg_write_wb,
    input  logic [1:0]       result_src_wb,
    input  logic [2:0]       funct3_wb,
    input  logic [XLEN-1:0]  alu_result_wb,
    input  logic [XLEN-1:0]  read_data_wb,
    input  logic [XLEN-1:0]  pc_p_4_wb,
    input  logic [AW-1:0]    rd_wb,
    input  logic [AW-1:0]    rs1_id,
    input  logic [AW-1:0]    rs2_id,
    output logic [XLEN-1:0]  rd1_id,
    output logic [XLEN-1:0]  rd2_id,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_we,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] SRC_RSVD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [XLEN-1:0]  regs [NREGS];
    logic [CNT_W-1:0] instret_q;
    logic [1:0]       off;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [XLEN-1:0]  load_data;

    // Lane extraction; off[0] is ignored for halfwords, LW and undefined funct3 pass the word
    always_comb begin
        off       = alu_result_wb[1:0];
        byte_lane = 8'(read_data_wb >> {off, 3'b000});
        half_lane = 16'(read_data_wb >> {off[1], 4'b0000});
        case (funct3_wb)
            F3_LB:   load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_lane};
            default: load_data = read_data_wb;
        endcase
    end

    always_comb begin
        wb_data = '0;
        case (result_src_wb)
            SRC_ALU:  wb_data = alu_result_wb;
            SRC_LOAD: wb_data = load_data;
            SRC_PC4:  wb_data = pc_p_4_wb;
            default:  wb_data = '0;
        endcase
    end

    assign wb_we = wb_valid & reg_write_wb & (rd_wb != '0) & (result_src_wb != SRC_RSVD);

    // Entry 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[rd_wb] <= wb_data;
        end
    end

    // Read ports with same-cycle write-through bypass
    always_comb begin
        rd1_id = regs[rs1_id];
        if (rs1_id == '0) begin
            rd1_id = '0;
        end else if (wb_we && (rs1_id == rd_wb)) begin
            rd1_id = wb_data;
        end
    end

    always_comb begin
        rd2_id = regs[rs2_id];
        if (rs2_id == '0) begin
            rd2_id = '0;
        end else if (wb_we && (rs2_id == rd_wb)) begin
            rd2_id = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (wb_valid) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;

endmodule
